// File: rtl/lfsr_word_seq.sv
// lfsr_word_seq: sequences a serial LFSR into WORD_WIDTH-bit words.
// Optional error injection on bit 0: define LFSR_WORD_SEQ_ERRINJ_EN.
module lfsr_word_seq #(
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  start,
    input  logic                  clear_first,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  lfsr_d_out,
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
    input  logic                  err_inj,
`endif
    output logic                  lfsr_enable,
    output logic                  lfsr_clear,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = $clog2(WORD_WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_OUTPUT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [CNT_WIDTH-1:0]  remain_q, remain_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  in_bit;

    // Incoming serial bit, optionally corrupted on the final shift.
    always_comb begin
        in_bit = lfsr_d_out;
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
        if (bit_q == '0) begin
            in_bit = lfsr_d_out ^ err_inj;
        end
`endif
    end

    // State, word, remaining-count and bit-position registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            remain_q <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            remain_q <= remain_d;
            bit_q    <= bit_d;
        end
    end

    // Next-state logic; count is captured only when leaving IDLE.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        remain_d = remain_q;
        bit_d    = bit_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    remain_d = num_words;
                    bit_d    = LAST;
                    if (num_words == '0) begin
                        state_d = S_DONE;
                    end else if (clear_first) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                word_d = {word_q[WORD_WIDTH-2:0], in_bit};
                if (bit_q == '0) begin
                    state_d = S_OUTPUT;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            S_OUTPUT: begin
                if (word_ready) begin
                    remain_d = remain_q - 1'b1;
                    bit_d    = LAST;
                    if (remain_q == CNT_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    assign lfsr_enable = (state_q == S_SHIFT);
    assign lfsr_clear  = (state_q == S_CLEAR);
    assign word_valid  = (state_q == S_OUTPUT);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign word_data   = word_q;

endmodule

// File: tb/tb_lfsr_word_seq.sv
// tb_lfsr_word_seq: directed checks for lfsr_word_seq.
// Main instance W=8/C=16, small instance W=4/C=2 for max-count run.
module tb_lfsr_word_seq;

    logic        clk;
    logic        res_n;
    logic        start;
    logic        clear_first;
    logic [15:0] num_words;
    logic        d_in;
    logic        lfsr_enable;
    logic        lfsr_clear;
    logic [7:0]  word_data;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic        done;
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
    logic        err_inj;
`endif

    logic        s_start;
    logic [1:0]  s_num;
    logic        s_en;
    logic        s_clr;
    logic [3:0]  s_data;
    logic        s_valid;
    logic        s_busy;
    logic        s_done;

    logic [1:0]  mode;
    logic        alt;
    logic        alt_rst;

    int checks;
    int errors;

    lfsr_word_seq #(.WORD_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .res_n       (res_n),
        .start       (start),
        .clear_first (clear_first),
        .num_words   (num_words),
        .lfsr_d_out  (d_in),
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
        .err_inj     (err_inj),
`endif
        .lfsr_enable (lfsr_enable),
        .lfsr_clear  (lfsr_clear),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .done        (done)
    );

    lfsr_word_seq #(.WORD_WIDTH(4), .CNT_WIDTH(2)) u_small (
        .clk         (clk),
        .res_n       (res_n),
        .start       (s_start),
        .clear_first (1'b0),
        .num_words   (s_num),
        .lfsr_d_out  (1'b1),
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
        .err_inj     (1'b0),
`endif
        .lfsr_enable (s_en),
        .lfsr_clear  (s_clr),
        .word_data   (s_data),
        .word_valid  (s_valid),
        .word_ready  (1'b1),
        .busy        (s_busy),
        .done        (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Alternating source: 1 on first shift, toggles per enabled cycle.
    always @(posedge clk) begin
        if (alt_rst) alt <= 1'b1;
        else if (lfsr_enable) alt <= ~alt;
    end

    always_comb begin
        d_in = mode[0];
        if (mode == 2'd2) d_in = alt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_alt();
        alt_rst = 1'b1;
        tick();
        alt_rst = 1'b0;
    endtask

    task automatic do_start(input logic cf, input logic [15:0] n);
        start       = 1'b1;
        clear_first = cf;
        num_words   = n;
        tick();
        start       = 1'b0;
        clear_first = 1'b0;
        num_words   = '0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        res_n = 1'b0;
        tick();
        tick();
        obs = {lfsr_enable, lfsr_clear, word_valid, busy, done, word_data};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        res_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({busy, word_valid, lfsr_enable} !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_autostart got=%b want=000",
                     {busy, word_valid, lfsr_enable});
        end
    endtask

    task automatic test_ones();
        int words, dones, ens, first_v;
        mode = 2'd1;
        word_ready = 1'b1;
        words = 0; dones = 0; ens = 0; first_v = -1;
        do_start(1'b0, 16'd2);
        for (int i = 0; i < 60; i++) begin
            if (lfsr_enable) ens++;
            if (word_valid && first_v < 0) first_v = i;
            if (word_valid && word_ready) begin
                words++;
                checks++;
                if (word_data !== 8'hFF) begin
                    errors++;
                    $display("FAIL ones_word got=%h want=ff", word_data);
                end
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if (words != 2) begin
            errors++;
            $display("FAIL ones_count got=%0d want=2", words);
        end
        checks++;
        if (first_v != 8) begin
            errors++;
            $display("FAIL ones_latency got=%0d want=8", first_v);
        end
        checks++;
        if (ens != 16) begin
            errors++;
            $display("FAIL ones_enables got=%0d want=16", ens);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ones_done got=%0d want=1", dones);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ones_busy_end got=%b want=0", busy);
        end
    endtask

    task automatic test_alt_clear();
        int clrs, clr_i, en_i, v_i;
        logic [7:0] w;
        mode = 2'd2;
        word_ready = 1'b1;
        clrs = 0; clr_i = -1; en_i = -1; v_i = -1;
        w = '0;
        reset_alt();
        do_start(1'b1, 16'd1);
        for (int i = 0; i < 30; i++) begin
            if (lfsr_clear) begin
                clrs++;
                if (clr_i < 0) clr_i = i;
            end
            if (lfsr_enable && en_i < 0) en_i = i;
            if (word_valid && v_i < 0) begin
                v_i = i;
                w = word_data;
            end
            tick();
        end
        checks++;
        if (clrs != 1 || clr_i != 0) begin
            errors++;
            $display("FAIL clear_pulse got=%0d@%0d want=1@0", clrs, clr_i);
        end
        checks++;
        if (en_i != 1) begin
            errors++;
            $display("FAIL clear_then_enable got=%0d want=1", en_i);
        end
        checks++;
        if (v_i != 9) begin
            errors++;
            $display("FAIL clear_latency got=%0d want=9", v_i);
        end
        checks++;
        if (w !== 8'hAA) begin
            errors++;
            $display("FAIL alt_word got=%h want=aa", w);
        end
    endtask

    task automatic test_stall();
        int n;
        mode = 2'd2;
        word_ready = 1'b0;
        reset_alt();
        do_start(1'b0, 16'd1);
        n = 0;
        while (!word_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!word_valid) begin
            errors++;
            $display("FAIL stall_timeout got=0 want=1");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({word_valid, lfsr_enable, word_data} !== {2'b10, 8'hAA}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%b%b_%h want=10_aa",
                         i, word_valid, lfsr_enable, word_data);
            end
            tick();
        end
        word_ready = 1'b1;
        tick();
        checks++;
        if ({done, word_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stall_release got=%b want=10", {done, word_valid});
        end
        tick();
    endtask

    task automatic test_zero();
        int hi;
        word_ready = 1'b1;
        hi = 0;
        do_start(1'b0, 16'd0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done got=%b want=1", done);
        end
        for (int i = 0; i < 5; i++) begin
            if (lfsr_enable || word_valid) hi++;
            tick();
        end
        checks++;
        if (hi != 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet got=%0d/%b%b want=0/00", hi, busy, done);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] obs;
        int seen;
        mode = 2'd1;
        word_ready = 1'b1;
        do_start(1'b0, 16'd1);
        tick();
        tick();
        tick();
        checks++;
        if (lfsr_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_shift got=%b want=1", lfsr_enable);
        end
        res_n = 1'b0;
        #1;
        obs = {lfsr_enable, lfsr_clear, word_valid, busy, done, word_data};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h want=0", obs);
        end
        #2;
        res_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (word_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_no_resume got=%0d want=0", seen);
        end
        do_start(1'b0, 16'd1);
        for (int i = 0; i < 20 && !word_valid; i++) tick();
        checks++;
        if ({word_valid, word_data} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL mid_restart got=%b_%h want=1_ff",
                     word_valid, word_data);
        end
        tick();
        tick();
    endtask

    task automatic test_busy_ignore();
        int words, clrs, dones;
        mode = 2'd0;
        word_ready = 1'b1;
        words = 0; clrs = 0; dones = 0;
        do_start(1'b0, 16'd1);
        tick();
        do_start(1'b1, 16'd5);
        for (int i = 0; i < 40; i++) begin
            if (word_valid) words++;
            if (lfsr_clear) clrs++;
            if (done) dones++;
            tick();
        end
        checks++;
        if (words != 1 || clrs != 0 || dones != 1) begin
            errors++;
            $display("FAIL busy_ignore got=w%0d c%0d d%0d want=w1 c0 d1",
                     words, clrs, dones);
        end
    endtask

    task automatic test_errinj();
        logic [7:0] exp;
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
        exp = 8'h01;
`else
        exp = 8'h00;
`endif
        mode = 2'd0;
        word_ready = 1'b1;
        do_start(1'b0, 16'd1);
        for (int i = 0; i < 7; i++) tick();
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
        err_inj = 1'b1;
`endif
        tick();
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
        err_inj = 1'b0;
`endif
        checks++;
        if ({word_valid, word_data} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL errinj_word got=%b_%h want=1_%h",
                     word_valid, word_data, exp);
        end
        tick();
        tick();
    endtask

    task automatic test_max();
        int words, dones;
        words = 0; dones = 0;
        s_start = 1'b1;
        s_num   = 2'b11;
        tick();
        s_start = 1'b0;
        s_num   = 2'b00;
        for (int i = 0; i < 60; i++) begin
            if (s_valid) begin
                words++;
                checks++;
                if (s_data !== 4'hF) begin
                    errors++;
                    $display("FAIL max_word got=%h want=f", s_data);
                end
            end
            if (s_done) dones++;
            tick();
        end
        checks++;
        if (words != 3 || dones != 1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL max_count got=w%0d d%0d b%b want=w3 d1 b0",
                     words, dones, s_busy);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        res_n       = 1'b0;
        start       = 1'b0;
        clear_first = 1'b0;
        num_words   = '0;
        word_ready  = 1'b0;
        mode        = 2'd0;
        alt_rst     = 1'b1;
        s_start     = 1'b0;
        s_num       = '0;
`ifdef LFSR_WORD_SEQ_ERRINJ_EN
        err_inj     = 1'b0;
`endif
        test_reset();
        alt_rst = 1'b0;
        test_ones();
        test_alt_clear();
        test_stall();
        test_zero();
        test_reset_mid();
        test_busy_ignore();
        test_errinj();
        test_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_word_seq.md
LFSR_WORD_SEQ -- requirements
Module: lfsr_word_seq

Interface
- REQ-001: Parameter WORD_WIDTH, default 8, SHALL set bits per output word (legal range 2..64).
- REQ-002: Parameter CNT_WIDTH, default 16, SHALL set the width of the word-count command.
- REQ-003: clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
- REQ-004: res_n  in  1  SHALL be the asynchronous, active-low reset.
- REQ-005: start  in  1  SHALL request one run; it is sampled only in IDLE.
- REQ-006: clear_first  in  1  SHALL select a one-cycle LFSR clear before shifting; it is latched with start.
- REQ-007: num_words  in  CNT_WIDTH  SHALL give the number of words per run; it is latched with start.
- REQ-008: lfsr_d_out  in  1  SHALL be the serial bit from the sequenced LFSR.
- REQ-009: lfsr_enable  out  1  SHALL advance the LFSR by one bit per high cycle.
- REQ-010: lfsr_clear  out  1  SHALL zero the LFSR.
- REQ-011: word_data  out  WORD_WIDTH  SHALL carry the assembled word.
- REQ-012: word_valid  out  1 / word_ready  in  1  SHALL form the valid/ready output handshake.
- REQ-013: busy  out  1  SHALL be high whenever the FSM is not in IDLE.
- REQ-014: done  out  1  SHALL pulse high for exactly one cycle at the end of each run.

Function
- REQ-015: FSM states SHALL be IDLE, CLEAR, SHIFT, OUTPUT and DONE; all outputs SHALL decode from registered state (Moore).
- REQ-016: IDLE with start=1 SHALL go to DONE if num_words=0, else to CLEAR if clear_first=1, else to SHIFT.
- REQ-017: CLEAR SHALL last one cycle with lfsr_clear=1 and lfsr_enable=0, then go to SHIFT.
- REQ-018: SHIFT SHALL last exactly WORD_WIDTH cycles with lfsr_enable=1, then go to OUTPUT.
- REQ-019: Each SHIFT cycle SHALL shift lfsr_d_out into the LSB of the word register (first bit ends at the MSB).
- REQ-020: OUTPUT SHALL hold word_valid=1 and lfsr_enable=0, with word_data stable until word_valid && word_ready.
- REQ-021: On handshake, the remaining count SHALL decrement; the FSM SHALL go to DONE at 0, else to SHIFT.
- REQ-022: DONE SHALL last one cycle with done=1, then go to IDLE.
- REQ-023: Latency with clear_first=1: start at edge N SHALL give word_valid from cycle N+WORD_WIDTH+2; with clear_first=0, N+WORD_WIDTH+1.
- REQ-024: start while busy=1 SHALL be ignored; num_words and clear_first SHALL not be resampled mid-run.
- REQ-025: num_words=2^CNT_WIDTH-1 SHALL run to completion without counter wrap.
- REQ-026: word_ready outside OUTPUT SHALL have no effect.

Reset
- REQ-027: res_n=0 SHALL force IDLE immediately, including mid-run, and zero the word register and remaining count.
- REQ-028: During and after reset, lfsr_enable, lfsr_clear, word_valid, busy, done SHALL be 0 and word_data SHALL be all-zero.
- REQ-029: After reset release, the first run SHALL begin only on a new start.

Configuration
- REQ-030: With macro LFSR_WORD_SEQ_ERRINJ_EN defined, an input port err_inj (1 bit) SHALL exist.
- REQ-031: With the macro defined, err_inj=1 in the last SHIFT cycle SHALL invert bit 0 of that word when presented in OUTPUT.
- REQ-032: Without the macro, err_inj SHALL be absent and words SHALL be passed through unmodified.

Verification
- REQ-033: WORD_WIDTH=8, lfsr_d_out tied 1, num_words=2, ready=1 -> two words of 0xFF, then one done pulse, then busy=0.
- REQ-034: lfsr_d_out alternating 1,0,... starting at the first SHIFT cycle -> word 0xAA; clear_first=1 -> lfsr_clear high exactly one cycle before the first lfsr_enable.
- REQ-035: word_ready held low 5 cycles in OUTPUT -> word_valid=1, word_data constant, lfsr_enable=0 throughout.
- REQ-036: num_words=0 with start -> done on the cycle after the IDLE transition, lfsr_enable and word_valid never high.
- REQ-037: res_n pulsed low during the 4th SHIFT cycle -> all outputs 0 at once; no word_valid until a new start.
- REQ-038: With LFSR_WORD_SEQ_ERRINJ_EN, d_out tied 0 and err_inj=1 on the last SHIFT cycle -> word 0x01; without the macro -> 0x00.
